// File: rtl/sprite_pkg.sv
// Shared sprite definitions.
// The transmitter and the display core both use these sprite dimensions.
// Contents:
//   DEFAULT_SPRITE_WIDTH / DEFAULT_SPRITE_HEIGHT : sprite size in pixels
//   DEFAULT_NBITS : number of bits in one sprite upload
//   tx_state_t    : state of the serial transmitter
package sprite_pkg;

  localparam int DEFAULT_SPRITE_WIDTH  = 10;
  localparam int DEFAULT_SPRITE_HEIGHT = 10;
  localparam int DEFAULT_NBITS         = DEFAULT_SPRITE_WIDTH * DEFAULT_SPRITE_HEIGHT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sprite_spi_phase_timer.sv
// Phase timer for one spi_clk phase (low or high).
// It counts down from HALF_PERIOD-1 to 0 and then stays at 0 until it is
// reloaded. The terminal count is suppressed while hold is high. Because the
// counter saturates at 0, a held LOW phase stays ready and releases on the
// first cycle that hold is low.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   load         : restart the phase (reload HALF_PERIOD-1)
//   hold         : suppress the terminal count (the caller gates this to LOW)
//   tc           : phase complete and not held
module sprite_spi_phase_timer #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic hold,
  output logic tc
);

  localparam int CNT_W = $clog2(HALF_PERIOD);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc = (cnt_q == '0) && !hold;

endmodule

// File: rtl/sprite_spi_tx.sv
// Serial uploader for one sprite bitmap.
// A sprite word is accepted through a valid/ready handshake and sent MSB-first
// on spi_clk/spi_data. Data changes while spi_clk is low, and spi_clk rises in
// the middle of each bit. Each phase lasts HALF_PERIOD clk cycles, so spi_data
// is stable long enough for a receiver that uses a 2-FF synchroniser and a
// rising-edge detector.
// Ports:
//   clk, reset_n  : system clock, asynchronous active-low reset
//   sprite_in     : bitmap to send (bit NBITS-1 is sent first)
//   sprite_valid  : producer has a bitmap
//   sprite_ready  : transmitter is idle and can accept a bitmap
//   hold          : delay the start of the next bit (spi_clk stays low)
//   spi_clk       : serial clock, registered, idles low
//   spi_data      : serial data, registered, idles low
//   done          : one-cycle pulse when the last high phase ends
module sprite_spi_tx
  import sprite_pkg::*;
#(
  parameter int SPRITE_WIDTH  = DEFAULT_SPRITE_WIDTH,
  parameter int SPRITE_HEIGHT = DEFAULT_SPRITE_HEIGHT,
  parameter int HALF_PERIOD   = 4,
  localparam int NBITS        = SPRITE_WIDTH * SPRITE_HEIGHT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NBITS-1:0] sprite_in,
  input  logic             sprite_valid,
  output logic             sprite_ready,
  input  logic             hold,
  output logic             spi_clk,
  output logic             spi_data,
  output logic             done
);

  localparam int BITS_W = $clog2(NBITS + 1);

  generate
    if (HALF_PERIOD < 3) begin : g_bad_half_period
      $error("sprite_spi_tx: HALF_PERIOD must be at least 3");
    end
  endgenerate

  tx_state_t         state_q, state_d;
  // The bit currently on the wire lives in spi_data.
  // This register holds only the bits that are still waiting to be sent.
  logic [NBITS-2:0]  shift_q, shift_d;
  logic [BITS_W-1:0] bits_q, bits_d;
  logic              clk_d, data_d, done_d;
  logic              timer_load, phase_tc;

  assign sprite_ready = (state_q == IDLE);

  // Hold is honoured only in LOW. A bit that has already started always
  // finishes its HIGH phase.
  sprite_spi_phase_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .hold    (hold && (state_q == LOW)),
    .tc      (phase_tc)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    shift_d    = shift_q;
    bits_d     = bits_q;
    clk_d      = spi_clk;
    data_d     = spi_data;
    done_d     = 1'b0;
    timer_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_d = 1'b0;
        if (sprite_valid) begin
          state_d    = LOW;
          shift_d    = sprite_in[NBITS-2:0];
          bits_d     = BITS_W'(NBITS);
          data_d     = sprite_in[NBITS-1];
          timer_load = 1'b1;
        end
      end

      LOW: begin
        if (phase_tc) begin
          state_d    = HIGH;
          clk_d      = 1'b1;
          timer_load = 1'b1;
        end
      end

      HIGH: begin
        if (phase_tc) begin
          clk_d      = 1'b0;
          timer_load = 1'b1;
          if (bits_q > BITS_W'(1)) begin
            state_d = LOW;
            data_d  = shift_q[NBITS-2];
            shift_d = {shift_q[NBITS-3:0], 1'b0};
            bits_d  = bits_q - BITS_W'(1);
          end else begin
            // Last bit: return to idle with the data line low.
            // bits_left stays at 1 and does not wrap.
            state_d = IDLE;
            data_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the payload register is cleared with the control state, so an aborted upload leaves no stale bits behind.
      state_q  <= IDLE;
      shift_q  <= '0;
      bits_q   <= '0;
      spi_clk  <= 1'b0;
      spi_data <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments, so every flop samples the values from before the edge.
      state_q  <= state_d;
      shift_q  <= shift_d;
      bits_q   <= bits_d;
      spi_clk  <= clk_d;
      spi_data <= data_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_sprite_spi_tx.sv
// Self-checking bench for sprite_spi_tx.
// Each accepted word pushes its expected bits and its whole value onto
// scoreboard queues. Every spi_clk rise pops one expected bit. Every done
// pulse pops the word and compares it with a model of the display core's
// receiver (2-FF sync, rise detect, shift register).
module tb_sprite_spi_tx;
  import sprite_pkg::*;

  localparam int HP    = 4;
  localparam int NB    = DEFAULT_NBITS;
  localparam int XFER  = NB * 2 * HP;
  localparam int LIMIT = 4000;

  logic          clk;
  logic          reset_n;
  logic [NB-1:0] sprite_in;
  logic          sprite_valid;
  logic          sprite_ready;
  logic          hold;
  logic          spi_clk;
  logic          spi_data;
  logic          done;

  sprite_spi_tx #(
    .SPRITE_WIDTH  (DEFAULT_SPRITE_WIDTH),
    .SPRITE_HEIGHT (DEFAULT_SPRITE_HEIGHT),
    .HALF_PERIOD   (HP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sprite_in    (sprite_in),
    .sprite_valid (sprite_valid),
    .sprite_ready (sprite_ready),
    .hold         (hold),
    .spi_clk      (spi_clk),
    .spi_data     (spi_data),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cyc is the number of rising clk edges so far. At a falling-edge sample it
  // is the index of the edge that produced the values being observed.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the display core's receiver.
  logic          d1, d2, c1, c2, c3;
  logic [NB-1:0] rx;
  always @(posedge clk) begin
    d1 <= spi_data;
    d2 <= d1;
    c1 <= spi_clk;
    c2 <= c1;
    c3 <= c2;
    if (c2 && !c3) rx <= {rx[NB-2:0], d2};
  end

  // Scoreboard and monitor. Outputs are sampled on the falling clk edge.
  logic          bit_q[$];
  logic [NB-1:0] word_q[$];
  logic          prev_clk      = 1'b0;
  int            rise_cnt      = 0;
  int            done_cnt      = 0;
  int            accept_edge   = 0;
  int            last_done_cyc = 0;
  logic          first_pending = 1'b0;
  logic          first_exp     = 1'b0;
  int            stall_cycles  = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      bit_q.delete();
      word_q.delete();
      prev_clk      <= 1'b0;
      rise_cnt      <= 0;
      first_pending <= 1'b0;
    end else begin
      if (first_pending && cyc == accept_edge) begin
        check("first_bit", spi_data, first_exp);
        first_pending <= 1'b0;
      end
      if (spi_clk && !prev_clk) begin
        if (bit_q.size() == 0) check("unexpected_rise", 1, 0);
        else check("bit", spi_data, bit_q.pop_front());
        rise_cnt <= rise_cnt + 1;
      end
      prev_clk <= spi_clk;
      if (done) begin
        done_cnt      <= done_cnt + 1;
        last_done_cyc <= cyc;
        if (word_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("rx_word", rx, word_q.pop_front());
          check("done_time", cyc, accept_edge + XFER + stall_cycles);
          check("rise_count", rise_cnt, NB);
          check("ready_at_done", sprite_ready, 1);
        end
      end
      // Valid and ready at this sample means the accept happens on the next rising edge.
      if (sprite_valid && sprite_ready) begin
        for (int i = NB - 1; i >= 0; i--) bit_q.push_back(sprite_in[i]);
        word_q.push_back(sprite_in);
        accept_edge   <= cyc + 1;
        first_pending <= 1'b1;
        first_exp     <= sprite_in[NB-1];
        rise_cnt      <= 0;
      end
    end
  end

  task automatic send(input logic [NB-1:0] w);
    int t = 0;
    while (sprite_ready !== 1'b1 && t < LIMIT) begin
      @(posedge clk); #1; t++;
    end
    check("ready_wait", t < LIMIT, 1);
    sprite_in    = w;
    sprite_valid = 1'b1;
    @(posedge clk); #1;
    sprite_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n0 = done_cnt;
    int t  = 0;
    while (done_cnt == n0 && t < LIMIT) begin
      @(posedge clk); #1; t++;
    end
    check("done_wait", t < LIMIT, 1);
  endtask

  task automatic wait_rises(input int n);
    int t = 0;
    while (rise_cnt < n && t < LIMIT) begin
      @(posedge clk); #1; t++;
    end
    check("rise_wait", t < LIMIT, 1);
  endtask

  task automatic wait_level(input logic v);
    int t = 0;
    while (spi_clk !== v && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("level_wait", t < 100, 1);
  endtask

  function automatic logic [NB-1:0] checker_word();
    logic [NB-1:0] w = '0;
    for (int r = 0; r < DEFAULT_SPRITE_HEIGHT; r++)
      for (int c = 0; c < DEFAULT_SPRITE_WIDTH; c++)
        w[r*DEFAULT_SPRITE_WIDTH + c] = ((r + c) % 2 == 1);
    return w;
  endfunction

  initial begin
    logic [NB-1:0] w_a = 100'h9_A5F0_3C96_1234_5678_9ABC_DEF0;
    logic [NB-1:0] w_b = 100'h5_0F0F_1E2D_3C4B_5A69_7887_96A5;
    logic [NB-1:0] w_c = 100'hC_3333_CCCC_5555_AAAA_0000_FFFF;
    logic [NB-1:0] w_d = 100'h8_0000_0000_0000_0000_0000_0001;
    int high_n, bad_data, n0, t;

    sprite_in    = '0;
    sprite_valid = 1'b0;
    hold         = 1'b0;
    reset_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_spi_clk", spi_clk, 0);
    check("rst_spi_data", spi_data, 0);
    check("rst_ready", sprite_ready, 1);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Only the LSB is set: 99 zeros, then a single 1 on the 100th rise.
    send(100'h1);
    wait_done();

    // Checkerboard through the receiver model.
    send(checker_word());
    wait_done();

    // Hold during the LOW phase of bit 50. Hold is raised in the terminal LOW
    // cycle and kept for 20 cycles, so done is 20 cycles later.
    stall_cycles = 20;
    send(w_a);
    wait_rises(49);
    wait_level(1'b0);
    repeat (3) begin @(posedge clk); #1; end
    hold     = 1'b1;
    high_n   = 0;
    bad_data = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (spi_clk) high_n++;
      if (spi_data !== w_a[50]) bad_data++;
    end
    hold = 1'b0;
    check("hold_low_clk_high", high_n, 0);
    check("hold_low_data_changes", bad_data, 0);
    wait_done();

    // Hold raised in the first HIGH cycle for 10 cycles. HIGH still lasts 4
    // cycles, and the following LOW stalls for 3 cycles.
    stall_cycles = 3;
    send(w_b);
    wait_rises(10);
    wait_level(1'b0);
    wait_level(1'b1);
    hold   = 1'b1;
    high_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (spi_clk) high_n++;
    end
    hold = 1'b0;
    check("hold_high_width", high_n, HP);
    wait_done();

    // Back-to-back: sprite_valid stays high, and the second accept happens in the done cycle.
    stall_cycles = 0;
    sprite_in    = w_a;
    sprite_valid = 1'b1;
    @(posedge clk); #1;
    sprite_in = w_b;
    t = 0;
    while (done !== 1'b1 && t < LIMIT) begin
      @(posedge clk); #1; t++;
    end
    check("b2b_done_wait", t < LIMIT, 1);
    @(posedge clk); #1;
    sprite_valid = 1'b0;
    check("b2b_accepted", sprite_ready, 0);
    check("b2b_gap", accept_edge, last_done_cyc + 1);
    wait_done();

    // Reset in the HIGH phase of bit 37 (the 63rd rise). Outputs clear at once and no done pulse follows.
    send(w_c);
    wait_rises(63);
    check("pre_rst_clk", spi_clk, 1);
    check("pre_rst_data", spi_data, w_c[37]);
    n0      = done_cnt;
    reset_n = 1'b0;
    #1;
    check("abort_spi_clk", spi_clk, 0);
    check("abort_spi_data", spi_data, 0);
    check("abort_ready", sprite_ready, 1);
    check("abort_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, n0);
    send(w_d);
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
